// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_stall;

  logic              i_dma_req;
  logic              i_dma_we;
  logic [ADDR_W-1:0] i_dma_addr;
  logic [DATA_W-1:0] i_dma_wdata;
  logic              o_dma_gnt;
  logic [DATA_W-1:0] o_dma_rdata;
  logic              o_dma_rvalid;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_stall,
    input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    output o_dma_gnt, o_dma_rdata, o_dma_rvalid,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_stall,
    output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    input  o_dma_gnt, o_dma_rdata, o_dma_rvalid,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, DMA wins after
// STARVE_MAX consecutive denied cycles. Sequences 1-cycle-latency reads and drives the MEM stall.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CPU_RD, CPU_DONE, DMA_RD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic issue_ok, cpu_eligible, dma_wins, cpu_issue;

  // In CPU_DONE the CPU request still asserted is the read just served.
  assign issue_ok     = (state_q == IDLE) || (state_q == CPU_DONE);
  assign cpu_eligible = (state_q == IDLE) && bus.i_cpu_req;
  assign dma_wins     = issue_ok && bus.i_dma_req &&
                        ((cnt_q == 4'(STARVE_MAX)) || !cpu_eligible);
  assign cpu_issue    = cpu_eligible && !dma_wins;

  // NOTE: synchronous reset clears the FSM, counter and read register; no memories live here.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      IDLE, CPU_DONE: begin
        if (dma_wins)       state_d = bus.i_dma_we ? IDLE : DMA_RD;
        else if (cpu_issue) state_d = bus.i_cpu_we ? IDLE : CPU_RD;
        else                state_d = IDLE;
      end
      CPU_RD: begin
        cpu_rdata_d = bus.i_mem_rdata;
        state_d     = CPU_DONE;
      end
      DMA_RD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.i_dma_req && !dma_wins)
      cnt_d = (cnt_q == 4'(STARVE_MAX)) ? cnt_q : cnt_q + 4'd1;
    else
      cnt_d = '0;
  end

  // Combinational outputs are forced quiet during the reset cycle.
  always_comb begin
    bus.o_mem_en     = 1'b0;
    bus.o_mem_we     = 1'b0;
    bus.o_mem_addr   = {ADDR_W{1'b0}};
    bus.o_mem_wdata  = {DATA_W{1'b0}};
    bus.o_dma_gnt    = 1'b0;
    bus.o_dma_rvalid = 1'b0;
    bus.o_dma_rdata  = {DATA_W{1'b0}};
    bus.o_cpu_stall  = 1'b0;
    bus.o_cpu_rdata  = cpu_rdata_q;

    if (i_rst_n) begin
      if (dma_wins) begin
        bus.o_dma_gnt   = 1'b1;
        bus.o_mem_en    = 1'b1;
        bus.o_mem_we    = bus.i_dma_we;
        bus.o_mem_addr  = bus.i_dma_addr;
        bus.o_mem_wdata = bus.i_dma_wdata;
      end else if (cpu_issue) begin
        bus.o_mem_en    = 1'b1;
        bus.o_mem_we    = bus.i_cpu_we;
        bus.o_mem_addr  = bus.i_cpu_addr;
        bus.o_mem_wdata = bus.i_cpu_wdata;
      end

      if (state_q == DMA_RD) begin
        bus.o_dma_rvalid = 1'b1;
        bus.o_dma_rdata  = bus.i_mem_rdata;
      end

      bus.o_cpu_stall = bus.i_cpu_req &&
                        ((state_q == CPU_RD) || (state_q == DMA_RD) ||
                         ((state_q == IDLE) && (dma_wins || !bus.i_cpu_we)));
    end
  end

endmodule
